vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing_gen_wrap_counter.sv | 39 +++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
// Shared 640x480 @ 60 Hz timing constants for the VGA timing generator,
// plus a small decode helper used for the sync windows.
//   CW        : width of the horizontal and vertical counters
//   H_* / V_* : visible, front porch, sync, back porch and total lengths
//               (pixels per line / lines per frame)
package vga_pkg;

  localparam int CW = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // True when value lies in [lo, lo+len). The counter is widened to int so the
  // comparison against the integer bounds is unsigned-safe and width-clean.
  function automatic logic in_window(input logic [CW-1:0] value,
                                     input int lo,
                                     input int len);
    return (int'(value) >= lo) && (int'(value) < (lo + len));
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter
// Modulo-N up counter with a count enable. wrap is high on the enabled cycle
// in which the counter sits at MODULUS-1, i.e. the cycle it returns to 0.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; clears the count
//   en    : advance the count on this clock edge
//   count : current count, 0..MODULUS-1
//   wrap  : combinational, en && count == MODULUS-1
module wrap_counter
  import vga_pkg::*;
#(
  parameter int WIDTH   = CW,
  parameter int MODULUS = H_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Wrap is qualified by en so that a cascaded counter driven from it only
  // sees one pulse per full revolution of this counter.
  assign wrap = en && (count == LAST);

  // Count register: jump straight back to 0 from the last value so no
  // out-of-range value is ever visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Generates 640x480 VGA timing from a 50 MHz clock using a half-rate pixel
// enable, and registers pixel colour, syncs and blanking in a single output
// stage so all of them describe the same (hc,vc) position.
// Ports:
//   Clk                       : 50 MHz system clock
//   Reset                     : synchronous, active-high
//   Red_in/Green_in/Blue_in   : colour for the current DrawX/DrawY
//   DrawX/DrawY               : live horizontal/vertical counters
//   VGA_R/VGA_G/VGA_B         : registered colour, forced to 0 outside the visible area
//   VGA_HS/VGA_VS             : registered active-low syncs
//   VGA_BLANK_N               : registered, high in the visible area
//   VGA_SYNC_N                : constant 0
//   VGA_CLK                   : 25 MHz pixel clock (the pixel enable itself)
//   frame_start               : one-Clk strobe when (hc,vc) wraps to (0,0)
// The timing parameters default to the standard mode from vga_pkg; they are
// exposed so a reduced geometry can be elaborated for short simulations.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_SYN   = H_SYNC,
  parameter int H_BACK  = H_TOTAL - H_VISIBLE - H_FP - H_SYNC,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_SYN   = V_SYNC,
  parameter int V_BACK  = V_TOTAL - V_VISIBLE - V_FP - V_SYNC
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    Red_in,
  input  logic [7:0]    Green_in,
  input  logic [7:0]    Blue_in,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic          VGA_CLK,
  output logic          frame_start
);

  localparam int H_TOT = H_VIS + H_FRONT + H_SYN + H_BACK;
  localparam int V_TOT = V_VIS + V_FRONT + V_SYN + V_BACK;

  logic          pix_en;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          h_wrap;
  logic          v_wrap;
  logic          visible;
  logic          hs_active;
  logic          vs_active;

  // Pixel enable: 0 during reset, so the first edge after release raises it
  // and the second edge is the first one that advances the counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
    end
  end

  wrap_counter #(
    .WIDTH  (CW),
    .MODULUS(H_TOT)
  ) u_hcount (
    .clk  (Clk),
    .reset(Reset),
    .en   (pix_en),
    .count(hc),
    .wrap (h_wrap)
  );

  // The vertical counter advances only on the horizontal wrap, so at the last
  // pixel of the frame both counters return to 0 on the same edge and
  // v_wrap marks exactly that edge.
  wrap_counter #(
    .WIDTH  (CW),
    .MODULUS(V_TOT)
  ) u_vcount (
    .clk  (Clk),
    .reset(Reset),
    .en   (h_wrap),
    .count(vc),
    .wrap (v_wrap)
  );

  // Decode of the current (pre-advance) position; the output stage captures
  // it together with the colour that belongs to the same pixel.
  always_comb begin
    visible   = (int'(hc) < H_VIS) && (int'(vc) < V_VIS);
    hs_active = in_window(hc, H_VIS + H_FRONT, H_SYN);
    vs_active = in_window(vc, V_VIS + V_FRONT, V_SYN);
  end

  // Output stage. Everything except frame_start holds between pixel enables;
  // frame_start is a single-Clk strobe, so it is refreshed on every edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
      if (pix_en) begin
        VGA_R       <= visible ? Red_in   : 8'h00;
        VGA_G       <= visible ? Green_in : 8'h00;
        VGA_B       <= visible ? Blue_in  : 8'h00;
        VGA_HS      <= ~hs_active;
        VGA_VS      <= ~vs_active;
        VGA_BLANK_N <= visible;
      end
    end
  end

  assign DrawX      = hc;
  assign DrawY      = vc;
  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Drives two instances from one clock and reset: the standard 640x480 mode
// and a reduced geometry that completes whole frames quickly. A position
// model derived from the number of edges since reset predicts every output
// of both instances after every Clk edge; directed literal checks pin the
// reset sequence, sync widths, line/frame periods and the frame corner.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
    logic       vclk;
    logic       fs;
  } outs_t;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b1;
  logic [7:0] Red_in   = 8'h00;
  logic [7:0] Green_in = 8'h00;
  logic [7:0] Blue_in  = 8'h00;

  logic [9:0] big_x, big_y, small_x, small_y;
  logic [7:0] big_r, big_g, big_b, small_r, small_g, small_b;
  logic       big_hs, big_vs, big_bn, big_sn, big_vclk, big_fs;
  logic       small_hs, small_vs, small_bn, small_sn, small_vclk, small_fs;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int cyc    = 0;

  logic        rst_req = 1'b1;
  logic        ff_mode = 1'b0;
  logic [23:0] exp_col [2];

  // Geometry per instance: index 0 = standard mode, index 1 = reduced mode.
  int hv_a [2] = '{640, 16};
  int hf_a [2] = '{16, 4};
  int hs_a [2] = '{96, 8};
  int hb_a [2] = '{48, 4};
  int vv_a [2] = '{480, 12};
  int vf_a [2] = '{10, 2};
  int vs_a [2] = '{2, 2};
  int vb_a [2] = '{33, 3};

  int seq_x [4] = '{0, 1, 1, 2};
  int seq_c [4] = '{1, 0, 1, 0};

  always #10 Clk = ~Clk;

  vga_timing_gen u_big (
    .Clk(Clk), .Reset(Reset),
    .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
    .DrawX(big_x), .DrawY(big_y),
    .VGA_R(big_r), .VGA_G(big_g), .VGA_B(big_b),
    .VGA_HS(big_hs), .VGA_VS(big_vs), .VGA_BLANK_N(big_bn),
    .VGA_SYNC_N(big_sn), .VGA_CLK(big_vclk), .frame_start(big_fs)
  );

  vga_timing_gen #(
    .H_VIS(16), .H_FRONT(4), .H_SYN(8), .H_BACK(4),
    .V_VIS(12), .V_FRONT(2), .V_SYN(2), .V_BACK(3)
  ) u_small (
    .Clk(Clk), .Reset(Reset),
    .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
    .DrawX(small_x), .DrawY(small_y),
    .VGA_R(small_r), .VGA_G(small_g), .VGA_B(small_b),
    .VGA_HS(small_hs), .VGA_VS(small_vs), .VGA_BLANK_N(small_bn),
    .VGA_SYNC_N(small_sn), .VGA_CLK(small_vclk), .frame_start(small_fs)
  );

  // Is linear pixel index pk (pixels since reset) inside the visible area?
  function automatic logic is_visible(input int inst, input int pk);
    int ht, vt, ph, pv;
    ht = hv_a[inst] + hf_a[inst] + hs_a[inst] + hb_a[inst];
    vt = vv_a[inst] + vf_a[inst] + vs_a[inst] + vb_a[inst];
    ph = pk % ht;
    pv = (pk / ht) % vt;
    return (ph < hv_a[inst]) && (pv < vv_a[inst]);
  endfunction

  // Expected outputs after the nn-th non-reset edge: nn/2 pixels have been
  // advanced; registered outputs describe the pixel before the current one.
  function automatic outs_t model_outs(input int inst, input int nn, input logic [23:0] col);
    int ht, vt, k, pk, ph, pv, hlo, vlo;
    outs_t o;
    ht  = hv_a[inst] + hf_a[inst] + hs_a[inst] + hb_a[inst];
    vt  = vv_a[inst] + vf_a[inst] + vs_a[inst] + vb_a[inst];
    hlo = hv_a[inst] + hf_a[inst];
    vlo = vv_a[inst] + vf_a[inst];
    k   = nn / 2;
    o.x    = 10'(k % ht);
    o.y    = 10'((k / ht) % vt);
    o.vclk = (nn % 2) == 1;
    o.sn   = 1'b0;
    o.fs   = (nn >= 2) && ((nn % 2) == 0) && ((k % (ht * vt)) == 0);
    if (nn < 2) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.bn = 1'b0;
    end else begin
      pk   = k - 1;
      ph   = pk % ht;
      pv   = (pk / ht) % vt;
      o.hs = !((ph >= hlo) && (ph < hlo + hs_a[inst]));
      o.vs = !((pv >= vlo) && (pv < vlo + vs_a[inst]));
      o.bn = (ph < hv_a[inst]) && (pv < vv_a[inst]);
    end
    {o.r, o.g, o.b} = col;
    return o;
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_output(input int inst, input outs_t got);
    outs_t e;
    e = model_outs(inst, n, exp_col[inst]);
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bn=%b sn=%b clk=%b fs=%b expected x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bn=%b sn=%b clk=%b fs=%b",
               (inst == 0) ? "big" : "small", cyc,
               got.x, got.y, got.r, got.g, got.b, got.hs, got.vs, got.bn, got.sn, got.vclk, got.fs,
               e.x, e.y, e.r, e.g, e.b, e.hs, e.vs, e.bn, e.sn, e.vclk, e.fs);
    end
  endtask

  // One Clk cycle: drive inputs on the falling edge, advance the model on the
  // rising edge, then compare both instances just after it.
  task automatic apply_stimulus();
    int pk;
    @(negedge Clk);
    Reset = rst_req;
    if (ff_mode) begin
      Red_in   = 8'hFF;
      Green_in = 8'hFF;
      Blue_in  = 8'hFF;
    end else begin
      Red_in   = 8'($urandom);
      Green_in = 8'($urandom);
      Blue_in  = 8'($urandom);
    end
    @(posedge Clk);
    if (Reset) n = 0;
    else n = n + 1;
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        exp_col[i] = 24'h0;
      end else if ((n % 2) == 0) begin
        pk = n / 2 - 1;
        exp_col[i] = is_visible(i, pk) ? {Red_in, Green_in, Blue_in} : 24'h0;
      end
    end
    #1;
    cyc++;
    check_output(0, {big_x, big_y, big_r, big_g, big_b, big_hs, big_vs, big_bn, big_sn, big_vclk, big_fs});
    check_output(1, {small_x, small_y, small_r, small_g, small_b, small_hs, small_vs, small_bn, small_sn, small_vclk, small_fs});
  endtask

  initial begin
    int  cnt, first_low, k, t0, t1, prev_x, bad_hi, bad_lo;
    bit  found;
    exp_col[0] = 24'h0;
    exp_col[1] = 24'h0;
    $display("[TB] vga_timing_gen bench starting");

    // Reset held for three edges, then literal reset values.
    rst_req = 1'b1;
    ff_mode = 1'b0;
    repeat (3) apply_stimulus();
    check_val("reset_drawx", int'(big_x), 0);
    check_val("reset_drawy", int'(big_y), 0);
    check_val("reset_vga_clk", int'(big_vclk), 0);
    check_val("reset_hs", int'(big_hs), 1);
    check_val("reset_vs", int'(big_vs), 1);
    check_val("reset_blank_n", int'(big_bn), 0);
    check_val("reset_red", int'(big_r), 0);
    check_val("reset_frame_start", int'(big_fs), 0);

    // DrawX steps 0,1,1,2 and VGA_CLK toggles on the edges after release.
    rst_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus();
      check_val($sformatf("release_drawx_%0d", i), int'(big_x), seq_x[i]);
      check_val($sformatf("release_vga_clk_%0d", i), int'(big_vclk), seq_c[i]);
    end

    // Horizontal sync width and its one-pixel lag behind hc=656.
    ff_mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      apply_stimulus();
      if (big_x == 10'd656 && big_vclk == 1'b0) found = 1'b1;
    end
    check_val("wait_hc_656", int'(found), 1);
    cnt = 0; first_low = 0; k = 0; found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      apply_stimulus();
      k++;
      if (!big_hs) begin
        if (cnt == 0) first_low = k;
        cnt++;
      end else if (cnt > 0) begin
        found = 1'b1;
      end
    end
    check_val("hs_low_clks", cnt, 192);
    check_val("hs_first_low_edge", first_low, 2);

    // Line period and colour gating with a constant white input.
    bad_hi = 0; bad_lo = 0; t0 = -1; t1 = -1;
    prev_x = int'(big_x);
    for (int i = 0; i < 5000 && t1 < 0; i++) begin
      apply_stimulus();
      if (big_bn && big_r != 8'hFF) bad_hi++;
      if (!big_bn && big_r != 8'h00) bad_lo++;
      if (big_x == 10'd0 && prev_x == 799) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
      prev_x = int'(big_x);
    end
    check_val("line_period_clks", t1 - t0, 1600);
    check_val("rgb_white_when_visible", bad_hi, 0);
    check_val("rgb_zero_when_blank", bad_lo, 0);

    // Vertical sync width on the reduced geometry: 2 lines of 32 pixels.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      apply_stimulus();
      if (small_vs) found = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      apply_stimulus();
      if (!small_vs) found = 1'b1;
    end
    check_val("wait_small_vs_low", int'(found), 1);
    cnt = 1; found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      apply_stimulus();
      if (!small_vs) cnt++;
      else found = 1'b1;
    end
    check_val("small_vs_low_clks", cnt, 128);

    // Frame corner (31,18) with pixel enable high, then frame spacing.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      apply_stimulus();
      if (small_x == 10'd31 && small_y == 10'd18 && small_vclk) found = 1'b1;
    end
    check_val("wait_small_corner", int'(found), 1);
    apply_stimulus();
    check_val("corner_drawx", int'(small_x), 0);
    check_val("corner_drawy", int'(small_y), 0);
    check_val("corner_frame_start", int'(small_fs), 1);
    t0 = cyc;
    apply_stimulus();
    check_val("corner_frame_start_drop", int'(small_fs), 0);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      apply_stimulus();
      if (small_fs) found = 1'b1;
    end
    check_val("frame_spacing_clks", cyc - t0, 1216);

    // Reset asserted mid-line at hc=700.
    ff_mode = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      apply_stimulus();
      if (big_x == 10'd700) found = 1'b1;
    end
    check_val("wait_hc_700", int'(found), 1);
    rst_req = 1'b1;
    apply_stimulus();
    check_val("midreset_drawx", int'(big_x), 0);
    check_val("midreset_drawy", int'(big_y), 0);
    check_val("midreset_hs", int'(big_hs), 1);
    check_val("midreset_vs", int'(big_vs), 1);
    check_val("midreset_frame_start", int'(big_fs), 0);
    check_val("midreset_small_frame_start", int'(small_fs), 0);
    rst_req = 1'b0;

    // Random run lengths with random reset pulses in between.
    for (int r = 0; r < 3; r++) begin
      k = int'($urandom_range(300, 1500));
      repeat (k) apply_stimulus();
      rst_req = 1'b1;
      k = int'($urandom_range(1, 3));
      repeat (k) apply_stimulus();
      rst_req = 1'b0;
    end

    // No pulse for the frame that begins out of reset; first one a full frame later.
    k = 0; found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      apply_stimulus();
      k++;
      if (small_fs) found = 1'b1;
    end
    check_val("first_frame_start_after_reset", k, 1216);
    repeat (200) apply_stimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
